// File: rtl/stack_pkg.sv
// Shared constants and types for the byte stack and its drain adapter.
package stack_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } drain_state_t;

  function automatic int clamp_len(
    input int len,
    input int depth
  );
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/stack_drain_adapter_fifo2.sv
// Two-entry skid FIFO with registered head/valid and an occupancy count.
module fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             deq;

  assign deq       = vld_q & rd_ready;
  assign rd_valid  = vld_q;
  assign rd_data   = head_q;
  assign occupancy = cnt_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (wr_en) begin
          head_d = wr_data;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        case ({wr_en, deq})
          2'b11: head_d = wr_data;
          2'b10: begin
            tail_d = wr_data;
            cnt_d  = 2'd2;
          end
          2'b01: cnt_d = 2'd0;
          default: ;
        endcase
      end
      2'd2: begin
        // Upstream credit guarantees no write lands here without a dequeue.
        if (deq) begin
          head_d = tail_q;
          if (wr_en) tail_d = wr_data;
          else cnt_d = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
    vld_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      vld_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/stack_drain_adapter.sv
// Pops a burst from the byte stack and replays it as a valid/ready
// stream, issuing pops only when the 2-entry buffer has room.
module stack_drain_adapter #(
  parameter int WIDTH = stack_pkg::WIDTH,
  parameter int DEPTH = stack_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       burst_len,
  input  logic             stk_empty,
  input  logic [WIDTH-1:0] stk_data,
  output logic             stk_pop,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             short
);

  import stack_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  drain_state_t  state_q, state_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          mode_all_q, mode_all_d;
  logic          inflight_q, inflight_d;
  logic          short_q, short_d;
  logic          busy_q, busy_d;

  logic [1:0]    occ;
  logic          deq;
  logic          credit_ok;
  logic          want;
  logic          pop;
  logic          fin;

  fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (inflight_q),
    .wr_data  (stk_data),
    .rd_valid (m_valid),
    .rd_data  (m_data),
    .rd_ready (m_ready),
    .occupancy(occ)
  );

  assign deq = m_valid & m_ready;

  // Counts the in-flight word so a new pop never overruns the buffer.
  assign credit_ok =
    (3'(occ) + 3'(inflight_q) - 3'(deq)) < 3'd2;

  assign want = mode_all_q | (remaining_q != '0);
  assign pop  = (state_q == DRAIN) & ~stk_empty
              & want & credit_ok;
  assign fin  = (state_q == FLUSH) & (occ == 2'd0)
              & ~inflight_q;

  assign stk_pop = pop;
  assign done    = fin;
  assign busy    = busy_q;
  assign short   = short_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    mode_all_d  = mode_all_q;
    short_d     = short_q;
    inflight_d  = pop;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DRAIN;
          remaining_d = CW'(clamp_len(int'(burst_len), DEPTH));
          mode_all_d  = (burst_len == 4'd0);
          short_d     = 1'b0;
        end
      end
      DRAIN: begin
        if (pop && !mode_all_q)
          remaining_d = remaining_q - CW'(1);
        if (mode_all_q) begin
          if (stk_empty) state_d = FLUSH;
        end else if (pop && remaining_q == CW'(1)) begin
          state_d = FLUSH;
        end else if (stk_empty) begin
          state_d = FLUSH;
          short_d = 1'b1;
        end
      end
      FLUSH: begin
        if (fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      mode_all_q  <= 1'b0;
      inflight_q  <= 1'b0;
      short_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mode_all_q  <= mode_all_d;
      inflight_q  <= inflight_d;
      short_q     <= short_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_stack_drain_adapter.sv
// Bench for stack_drain_adapter: behavioural stack, LIFO reference
// model, table-driven bursts, reset sequence and random bursts.
module tb_stack_drain_adapter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] burst_len;
  logic       stk_empty;
  logic [7:0] stk_data;
  logic       stk_pop;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       busy;
  logic       done;
  logic       short_o;

  always #5 clk = ~clk;

  stack_drain_adapter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .burst_len(burst_len),
    .stk_empty(stk_empty),
    .stk_data (stk_data),
    .stk_pop  (stk_pop),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done),
    .short    (short_o)
  );

  // Behavioural 8-entry stack with one-cycle pop-to-data latency.
  logic [7:0] smem [8];
  int         scnt = 0;
  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      scnt     <= 0;
      stk_data <= 8'h00;
    end else if (stk_pop && scnt > 0) begin
      stk_data <= smem[scnt-1];
      scnt     <= scnt - 1;
    end else if (push_en && scnt < 8) begin
      smem[scnt] <= push_data;
      scnt       <= scnt + 1;
    end
  end

  assign stk_empty = (scnt == 0);

  int checks = 0;
  int errors = 0;

  logic [7:0] mstk [$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  int   neg_cnt = 0;
  int   first_neg = 0;
  int   last_neg = 0;
  int   pop_cnt = 0;
  int   done_cnt = 0;
  bit   done_seen = 0;
  bit   short_at_done = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_data = 8'h00;

  int rmode = 0;
  int bp_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_valid || m_data !== prev_data) begin
          errors++;
          $display("FAIL hold: valid=%0b data=%h required valid=1 data=%h",
                   m_valid, m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        if (got_q.size() == 0) first_neg = neg_cnt;
        last_neg = neg_cnt;
        got_q.push_back(m_data);
      end
      if (stk_pop) pop_cnt++;
      if (done) begin
        done_seen     = 1;
        done_cnt++;
        short_at_done = short_o;
        checks++;
        if (m_valid) begin
          errors++;
          $display("FAIL done_pending: m_valid=%0b required 0", m_valid);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
    neg_cnt++;
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bp_cnt++;
      case (rmode)
        1:       m_ready = ($urandom_range(0, 3) != 0);
        2:       m_ready = (bp_cnt <= 10) ? 1'b0 : bp_cnt[0];
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] v);
    push_en   = 1'b1;
    push_data = v;
    @(posedge clk);
    #1;
    push_en = 1'b0;
    mstk.push_back(v);
  endtask

  task automatic run_burst(
    input logic [3:0] len,
    input int         rm,
    input bit         lat,
    input bit         dbl,
    input int         tb_beats,
    input int         tb_short
  );
    int  sz;
    int  cl;
    int  n;
    int  start_neg;
    bit  exp_short;
    sz = mstk.size();
    cl = (int'(len) > 8) ? 8 : int'(len);
    n  = (len == 0) ? sz : ((cl < sz) ? cl : sz);
    exp_short = (len != 0) && (cl > sz);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mstk.pop_back());
    @(posedge clk);
    #1;
    got_q.delete();
    pop_cnt   = 0;
    done_cnt  = 0;
    done_seen = 0;
    rmode     = rm;
    bp_cnt    = 0;
    start     = 1'b1;
    burst_len = len;
    start_neg = neg_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 400 && !done_seen; k++) begin
      @(negedge clk);
      #1;
      if (rm == 2 && k == 7) chk("stall_pops", pop_cnt, 2);
      if (dbl && k == 1) begin
        start     = 1'b1;
        burst_len = 4'd1;
      end
      if (dbl && k == 2) start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", int'(done_seen), 1);
    chk("beats", got_q.size(), exp_q.size());
    if (tb_beats >= 0) chk("beats_tab", got_q.size(), tb_beats);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("data", int'(got_q[i]), int'(exp_q[i]));
    chk("short", int'(short_at_done), int'(exp_short));
    if (tb_short >= 0) chk("short_tab", int'(short_at_done), tb_short);
    chk("pops", pop_cnt, exp_q.size());
    if (lat) begin
      chk("latency", first_neg - start_neg, 3);
      chk("back2back", last_neg - first_neg, n - 1);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("busy_after", int'(busy), 0);
    chk("done_once", done_cnt, 1);
    rmode = 0;
  endtask

  typedef struct {
    int         n_push;
    logic [3:0] len;
    int         rm;
    bit         lat;
    bit         dbl;
    int         beats;
    int         shrt;
  } vec_t;

  vec_t       vt [8];
  logic [7:0] pv;

  initial begin
    vt[0] = '{3, 4'd3,  0, 1, 0, 3, 0};
    vt[1] = '{5, 4'd0,  0, 0, 0, 5, 0};
    vt[2] = '{2, 4'd6,  0, 0, 0, 2, 1};
    vt[3] = '{8, 4'd8,  2, 0, 0, 8, 0};
    vt[4] = '{8, 4'd15, 0, 0, 1, 8, 0};
    vt[5] = '{0, 4'd3,  0, 0, 0, 0, 1};
    vt[6] = '{6, 4'd4,  1, 0, 0, 4, 0};
    vt[7] = '{0, 4'd0,  1, 0, 0, 2, 0};

    reset     = 1'b1;
    start     = 1'b0;
    burst_len = 4'd0;
    pv        = 8'h11;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_pop", int'(stk_pop), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(short_o), 0);

    for (int v = 0; v < 8; v++) begin
      for (int p = 0; p < vt[v].n_push; p++) begin
        push(pv);
        pv = pv + 8'h11;
      end
      run_burst(vt[v].len, vt[v].rm, vt[v].lat, vt[v].dbl,
                vt[v].beats, vt[v].shrt);
      if (vt[v].len == 0) chk("empty_after", int'(stk_empty), 1);
    end

    // Reset in the middle of a burst.
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) push(8'hA0 + 8'(p));
    got_q.delete();
    rmode     = 0;
    start     = 1'b1;
    burst_len = 4'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 50 && got_q.size() < 2; k++) @(negedge clk);
    chk("rst_mid_beats", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("rst_mid_d0", int'(got_q[0]), 8'hA3);
      chk("rst_mid_d1", int'(got_q[1]), 8'hA2);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mstk.delete();
    @(negedge clk);
    #1;
    chk("mid_pop", int'(stk_pop), 0);
    chk("mid_valid", int'(m_valid), 0);
    chk("mid_data", int'(m_data), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_short", int'(short_o), 0);
    run_burst(4'd0, 0, 0, 0, 0, 0);
    run_burst(4'd5, 0, 0, 0, 0, 1);

    for (int it = 0; it < 40; it++) begin
      int np;
      np = $urandom_range(0, 8 - mstk.size());
      for (int p = 0; p < np; p++) push(8'($urandom));
      run_burst(4'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)), 0, 0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_drain_adapter.md
# stack_drain_adapter

- Sits directly downstream of the 8-entry byte stack.
- On a `start` command it pops a burst of entries from the stack and turns them into an 8-bit valid/ready stream for the next stage.
- Handles the stack's one-cycle pop-to-data latency and absorbs output backpressure in a 2-entry buffer.
- Pops are issued only when buffer space is guaranteed, so no data is lost.

## Interface

Parameters:
- `WIDTH`, 8, data width; must match the stack.
- `DEPTH`, 8, stack depth; sets the maximum burst length.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle burst request; ignored while `busy`=1.
- `burst_len` in 4: entries to pop, sampled with `start`. 0 means drain until the stack is empty. Values above `DEPTH` are clamped to `DEPTH`.
- `stk_empty` in 1: empty flag from the stack.
- `stk_data` in `WIDTH`: stack `data_out`; valid in the cycle after `stk_pop`.
- `stk_pop` out 1: pop request to the stack; combinational.
- `m_valid` out 1: output stream valid.
- `m_data` out `WIDTH`: output stream data.
- `m_ready` in 1: downstream ready.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when a burst completes.
- `short` out 1: registered flag, valid with `done`. Set when a fixed-length burst ended early because the stack went empty; cleared on the next accepted `start`.

## Operation

- FSM states: IDLE, DRAIN, FLUSH.
- IDLE → DRAIN when `start`=1. Latches `remaining` = clamp(`burst_len`) and `mode_all` = (`burst_len`==0), and clears `short`.
- `stk_pop` = (state==DRAIN) & !`stk_empty` & (`mode_all` | `remaining`!=0) & credit_ok.
- credit_ok = (occupancy + inflight − deq) < 2, where:
  - occupancy = buffer entries (0..2);
  - inflight = pop issued last cycle;
  - deq = `m_valid` & `m_ready`.
- Each pop decrements `remaining` (if not `mode_all`) and sets `inflight` for the next cycle. In that cycle `stk_data` is written into the buffer.
- DRAIN → FLUSH when any of these holds:
  - `remaining` reaches 0 (last pop issued);
  - `mode_all` and `stk_empty`=1;
  - not `mode_all`, `remaining`!=0 and `stk_empty`=1. Sets `short`=1.
- FLUSH → IDLE once occupancy==0 and inflight==0. `done` pulses in the cycle of that transition.
- A burst of length N yields exactly min(N, stack count) beats, in pop order (most recent push first). A burst on an already-empty stack yields zero beats, with `done` and, for fixed length, `short`=1.
- Stack pushes during a burst are allowed. In `mode_all` the burst continues until the stack is empty, so concurrent pushes extend it.
- Any `reset` mid-burst:
  - returns the FSM to IDLE;
  - discards buffered and in-flight data;
  - drives all outputs to reset values next cycle;
  - the stack is reset by the same `reset`.

## Timing

- Reset values: `stk_pop`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `short`=0.
- `start` sampled at edge E0.
- First `stk_pop` can occur in the cycle after E0.
- Each word reaches `m_valid` 2 cycles after its `stk_pop`.
- Start-to-first-beat latency: 3 cycles.
- Throughput: one beat per cycle while `m_ready`=1 and the stack is non-empty.
- `m_valid`/`m_data` follow AXI-stream rules:
  - once asserted, they hold stable until `m_ready`=1;
  - transfer happens when both are high.
- With `m_ready` held low the buffer fills to 2 and `stk_pop` stays low. No overrun.
- Simultaneous buffer write (from the in-flight pop) and `deq` in one cycle: both are honoured.
- `done` is coincident with the last FLUSH cycle, never with a beat still pending.

## Structure

- Package `stack_pkg`:
  - `WIDTH`, `DEPTH` constants;
  - `drain_state_t` enum (IDLE/DRAIN/FLUSH);
  - shared with the stack.
- Sub-module `fifo2`: a 2-entry FIFO with registered outputs and an `occupancy` output. The adapter holds only the FSM, counters and credit logic.

## Test plan

- **Basic:** push 0x11,0x22,0x33; `start`, `burst_len`=3, `m_ready`=1 → beats 0x33,0x22,0x11 on consecutive cycles; first beat 3 cycles after `start`; `done`=1, `short`=0.
- **Drain all:** push 5 bytes; `burst_len`=0 → 5 beats in reverse push order; `stk_empty`=1; `done`.
- **Short:** push 2 bytes; `burst_len`=6 → 2 beats; `done` with `short`=1; exactly 2 `stk_pop` pulses.
- **Backpressure:** 8-byte stack, `burst_len`=8, `m_ready` low for 10 cycles then toggling 1/0 → occupancy never exceeds 2; data held stable while stalled; all 8 beats in order.
- **Reset mid-burst:** `reset` pulsed after the 2nd beat → next cycle all outputs at reset values, `busy`=0; a new `start` on an empty stack gives zero beats and `done`.
- **Start while busy / clamp:** second `start` during DRAIN is ignored; `burst_len`=15 on a full stack gives exactly 8 beats.
